// File: rtl/avalon_s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avalon_s_pkg
// Brief    : Shared types for the Avalon weighted round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package avalon_s_pkg;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/avalon_s_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : avalon_s_rr_pick
// Brief    : Combinational round-robin picker; searches from i_ptr+1 upward.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_s_rr_pick #(
    parameter int NH = 2,
    parameter int IW = $clog2(NH)
) (
    input  logic [NH-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [NH-1:0] o_winner,
    output logic [IW-1:0] o_winner_idx,
    output logic          o_valid
);

    localparam int c_SW = IW + 2;

    logic [NH-1:0]   w_rot;
    logic [IW-1:0]   w_off;
    logic [c_SW-1:0] w_sum;

    always_comb begin
        // Shift of the doubled vector rotates so bit 0 corresponds to host ptr+1
        w_rot = NH'({i_req, i_req} >> (c_SW'(i_ptr) + c_SW'(1)));
        w_off = '0;
        for (int i = NH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IW'(i);
            end
        end
        w_sum = c_SW'(i_ptr) + c_SW'(w_off) + c_SW'(1);
        if (w_sum >= c_SW'(NH)) begin
            w_sum = w_sum - c_SW'(NH);
        end
        o_winner_idx = w_sum[IW-1:0];
        o_valid      = |i_req;
        o_winner     = o_valid ? (NH'(1) << o_winner_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/avalon_s_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : avalon_s_wrr_arbiter
// Brief    : Weighted round-robin arbiter sharing one Avalon device among NH hosts.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_s_wrr_arbiter
    import avalon_s_pkg::*;
#(
    parameter int NH = 2,
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int WW = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NH-1:0]                hosts_avn_read,
    input  logic [NH-1:0]                hosts_avn_write,
    input  logic [NH-1:0][AW-1:0]        hosts_avn_address,
    input  logic [NH-1:0][DW/8-1:0]      hosts_avn_byte_enable,
    input  logic [NH-1:0][DW-1:0]        hosts_avn_writedata,
    output logic [NH-1:0][DW-1:0]        hosts_avn_readdata,
    output logic [NH-1:0]                hosts_avn_waitrequest,
    output logic                         device_avn_read,
    output logic                         device_avn_write,
    output logic [AW-1:0]                device_avn_address,
    output logic [DW/8-1:0]              device_avn_byte_enable,
    output logic [DW-1:0]                device_avn_writedata,
    input  logic [DW-1:0]                device_avn_readdata,
    input  logic                         device_avn_waitrequest,
    input  logic [NH-1:0][WW-1:0]        cfg_weight,
    output logic [NH-1:0]                grant
);

    localparam int             IW          = $clog2(NH);
    localparam logic [IW-1:0]  c_PTR_RESET = IW'(NH - 1);

    arb_state_t    r_state_q,  w_state_d;
    logic [NH-1:0] r_grant_q,  w_grant_d;
    logic [IW-1:0] r_gidx_q,   w_gidx_d;
    logic [IW-1:0] r_ptr_q,    w_ptr_d;
    logic [WW-1:0] r_credit_q, w_credit_d;

    logic [NH-1:0] w_req;
    logic [NH-1:0] w_pick;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic [WW-1:0] w_pick_weight;
    logic          w_greq;
    logic          w_accept;

    assign w_req         = hosts_avn_read | hosts_avn_write;
    assign w_pick_weight = cfg_weight[w_pick_idx];
    assign w_greq        = w_req[r_gidx_q];
    assign w_accept      = (r_state_q == GRANT) && w_greq && !device_avn_waitrequest;
    assign grant         = r_grant_q;

    avalon_s_rr_pick #(
        .NH (NH),
        .IW (IW)
    ) u_pick (
        .i_req        (w_req),
        .i_ptr        (r_ptr_q),
        .o_winner     (w_pick),
        .o_winner_idx (w_pick_idx),
        .o_valid      (w_pick_valid)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_grant_d  = r_grant_q;
        w_gidx_d   = r_gidx_q;
        w_ptr_d    = r_ptr_q;
        w_credit_d = r_credit_q;
        case (r_state_q)
            ARB: begin
                if (w_pick_valid) begin
                    w_state_d  = GRANT;
                    w_grant_d  = w_pick;
                    w_gidx_d   = w_pick_idx;
                    w_ptr_d    = w_pick_idx;
                    w_credit_d = (w_pick_weight == '0) ? WW'(1) : w_pick_weight;
                end
            end
            GRANT: begin
                // A dropped request is treated like the final accept: release
                if (!w_greq || (w_accept && (r_credit_q <= WW'(1)))) begin
                    w_state_d  = ARB;
                    w_grant_d  = '0;
                    w_credit_d = '0;
                end else if (w_accept) begin
                    w_credit_d = r_credit_q - WW'(1);
                end
            end
            default: begin
                w_state_d = ARB;
                w_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= ARB;
            r_grant_q  <= '0;
            r_gidx_q   <= '0;
            r_ptr_q    <= c_PTR_RESET;
            r_credit_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_grant_q  <= w_grant_d;
            r_gidx_q   <= w_gidx_d;
            r_ptr_q    <= w_ptr_d;
            r_credit_q <= w_credit_d;
        end
    end

    always_comb begin
        device_avn_read        = 1'b0;
        device_avn_write       = 1'b0;
        device_avn_address     = '0;
        device_avn_byte_enable = '0;
        device_avn_writedata   = '0;
        if (r_state_q == GRANT) begin
            device_avn_read        = hosts_avn_read[r_gidx_q];
            device_avn_write       = hosts_avn_write[r_gidx_q];
            device_avn_address     = hosts_avn_address[r_gidx_q];
            device_avn_byte_enable = hosts_avn_byte_enable[r_gidx_q];
            device_avn_writedata   = hosts_avn_writedata[r_gidx_q];
        end
    end

    for (genvar h = 0; h < NH; h++) begin : g_host
        assign hosts_avn_waitrequest[h] = !((r_state_q == GRANT) && r_grant_q[h] &&
                                            !device_avn_waitrequest);
        assign hosts_avn_readdata[h]    = device_avn_readdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_s_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_s_wrr_arbiter
// Brief    : Directed and randomized bench with a behavioural arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_s_wrr_arbiter;

    localparam int NH = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int WW = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NH-1:0]           rd, wr;
    logic [NH-1:0][AW-1:0]   addr;
    logic [NH-1:0][DW/8-1:0] be;
    logic [NH-1:0][DW-1:0]   wd;
    logic [NH-1:0][DW-1:0]   h_rdata;
    logic [NH-1:0]           h_wait;
    logic                    d_read, d_write;
    logic [AW-1:0]           d_addr;
    logic [DW/8-1:0]         d_be;
    logic [DW-1:0]           d_wd;
    logic [DW-1:0]           d_rdata;
    logic                    d_wait;
    logic [NH-1:0][WW-1:0]   weight;
    logic [NH-1:0]           grant;

    always #5 clk = ~clk;

    avalon_s_wrr_arbiter #(.NH(NH), .DW(DW), .AW(AW), .WW(WW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .hosts_avn_read         (rd),
        .hosts_avn_write        (wr),
        .hosts_avn_address      (addr),
        .hosts_avn_byte_enable  (be),
        .hosts_avn_writedata    (wd),
        .hosts_avn_readdata     (h_rdata),
        .hosts_avn_waitrequest  (h_wait),
        .device_avn_read        (d_read),
        .device_avn_write       (d_write),
        .device_avn_address     (d_addr),
        .device_avn_byte_enable (d_be),
        .device_avn_writedata   (d_wd),
        .device_avn_readdata    (d_rdata),
        .device_avn_waitrequest (d_wait),
        .cfg_weight             (weight),
        .grant                  (grant)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: granted host (-1 = none), remaining credit, last winner
    int m_gnt, m_cred, m_ptr;
    int run_host[$];
    int run_len[$];
    int cur_host, cur_len;
    logic [NH-1:0] grant_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt      = -1;
        m_cred     = 0;
        m_ptr      = NH - 1;
        cur_host   = -1;
        cur_len    = 0;
        grant_seen = '0;
        run_host.delete();
        run_len.delete();
    endtask

    task automatic rand_data();
        for (int h = 0; h < NH; h++) begin
            addr[h] = $urandom;
            be[h]   = 4'($urandom);
            wd[h]   = $urandom;
        end
        d_rdata = $urandom;
    endtask

    // Called just after a falling edge with inputs set; checks, then advances one cycle
    task automatic step();
        logic [NH-1:0] req;
        int  acc, cand;
        bit  found;
        #1;
        req = rd | wr;
        chk("grant", 64'(grant), (m_gnt >= 0) ? (64'd1 << m_gnt) : 64'd0);
        if (m_gnt >= 0) begin
            chk("dev_read",  64'(d_read),  64'(rd[m_gnt]));
            chk("dev_write", 64'(d_write), 64'(wr[m_gnt]));
            chk("dev_addr",  64'(d_addr),  64'(addr[m_gnt]));
            chk("dev_be",    64'(d_be),    64'(be[m_gnt]));
            chk("dev_wdata", 64'(d_wd),    64'(wd[m_gnt]));
        end else begin
            chk("idle_rw",    {62'd0, d_read, d_write}, 64'd0);
            chk("idle_addr",  64'(d_addr), 64'd0);
            chk("idle_be_wd", {28'd0, d_be, d_wd}, 64'd0);
        end
        for (int h = 0; h < NH; h++) begin
            chk("waitreq", 64'(h_wait[h]), (m_gnt == h && !d_wait) ? 64'd0 : 64'd1);
            chk("rdata",   64'(h_rdata[h]), 64'(d_rdata));
        end
        acc = -1;
        for (int h = 0; h < NH; h++) begin
            if (req[h] && !h_wait[h]) acc = h;
        end
        if (acc >= 0) begin
            if (cur_len > 0 && cur_host == acc) begin
                cur_len++;
            end else begin
                if (cur_len > 0) begin
                    run_host.push_back(cur_host);
                    run_len.push_back(cur_len);
                end
                cur_host = acc;
                cur_len  = 1;
            end
        end else if (cur_len > 0) begin
            run_host.push_back(cur_host);
            run_len.push_back(cur_len);
            cur_len = 0;
        end
        grant_seen |= grant;
        if (!rst) begin
            if (m_gnt < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NH; k++) begin
                    cand = (m_ptr + k) % NH;
                    if (!found && req[cand]) begin
                        found  = 1'b1;
                        m_gnt  = cand;
                        m_cred = (weight[cand] == '0) ? 1 : int'(weight[cand]);
                    end
                end
                if (found) m_ptr = m_gnt;
            end else if (!req[m_gnt]) begin
                m_gnt = -1;
            end else if (!d_wait) begin
                if (m_cred == 1) m_gnt = -1;
                else m_cred--;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        rd     = '0;
        wr     = '0;
        d_wait = 1'b0;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            rand_data();
            step();
        end
    endtask

    task automatic chk_run(input string tag, input int idx, input int host, input int len);
        int oh, ol;
        oh = (idx < run_host.size()) ? run_host[idx] : -1;
        ol = (idx < run_len.size())  ? run_len[idx]  : -1;
        chk({tag, "_host"}, 64'(oh), 64'(host));
        chk({tag, "_len"},  64'(ol), 64'(len));
    endtask

    initial begin
        rst    = 1'b1;
        rd     = '0;
        wr     = '0;
        d_wait = 1'b0;
        weight = '0;
        rand_data();
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_wait", 64'(h_wait), 64'hF);
        chk("reset_grant", 64'(grant), 64'd0);
        step();
        rst = 1'b0;

        // Asynchronous reset while host 0 is stalled mid-read
        do_reset();
        addr[0] = 32'h1000_0040;
        rd      = 4'b0001;
        d_wait  = 1'b1;
        step();
        step();
        chk("pre_rst_read", 64'(d_read), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_read",  64'(d_read), 64'd0);
        chk("rst_wait",  64'(h_wait), 64'hF);
        chk("rst_grant", 64'(grant),  64'd0);
        rd     = '0;
        d_wait = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Weighted share 3:1 with continuous writes
        do_reset();
        weight    = '0;
        weight[0] = 4'd3;
        weight[1] = 4'd1;
        wr        = 4'b0011;
        run(20);
        chk_run("share0", 0, 0, 3);
        chk_run("share1", 1, 1, 1);
        chk_run("share2", 2, 0, 3);
        chk_run("share3", 3, 1, 1);
        wr = '0;

        // Device stall holds grant and address for five cycles
        do_reset();
        weight[1] = 4'd1;
        addr[1]   = 32'hA5A5_0001;
        rd        = 4'b0010;
        d_wait    = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_grant", 64'(grant),     64'h2);
            chk("stall_addr",  64'(d_addr),    64'hA5A5_0001);
            chk("stall_w0",    64'(h_wait[0]), 64'd1);
            chk("stall_w1",    64'(h_wait[1]), 64'd1);
            step();
        end
        d_wait = 1'b0;
        #1;
        chk("stall_accept", 64'(h_wait[1]), 64'd0);
        step();
        rd = '0;

        // Weight 0 means a single accept per grant
        do_reset();
        weight = '0;
        rd     = 4'b0001;
        run(10);
        chk_run("w0_a", 0, 0, 1);
        chk_run("w0_b", 1, 0, 1);
        chk_run("w0_c", 2, 0, 1);

        // Weight change mid-grant applies to the next grant only
        do_reset();
        weight[0] = 4'd2;
        rd        = 4'b0001;
        step();
        step();
        weight[0] = 4'd4;
        run(12);
        chk_run("wchg_a", 0, 0, 2);
        chk_run("wchg_b", 1, 0, 4);
        rd = '0;

        // Wrap-around from ptr = NH-1 with hosts 3 and 0
        do_reset();
        weight = {4'd1, 4'd1, 4'd1, 4'd1};
        rd     = 4'b1001;
        run(12);
        chk_run("wrap_a", 0, 0, 1);
        chk_run("wrap_b", 1, 3, 1);
        chk_run("wrap_c", 2, 0, 1);
        chk_run("wrap_d", 3, 3, 1);
        chk("wrap_never12", 64'(grant_seen[2:1]), 64'd0);
        rd = '0;

        // Early drop inside a credit>1 grant
        do_reset();
        weight[0] = 4'd4;
        weight[1] = 4'd1;
        rd        = 4'b0011;
        step();
        step();
        rd[0] = 1'b0;
        #1;
        chk("drop_rw", {62'd0, d_read, d_write}, 64'd0);
        step();
        #1;
        chk("drop_arb", 64'(grant), 64'd0);
        step();
        #1;
        chk("drop_next", 64'(grant), 64'h2);
        step();
        rd = '0;

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rd     = NH'($urandom) & NH'($urandom);
            wr     = NH'($urandom) & NH'($urandom) & ~rd;
            d_wait = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 15) == 0) begin
                for (int h = 0; h < NH; h++) weight[h] = WW'($urandom);
            end
            rand_data();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
